mct_step_controller: RTL and testbench
======================================

Name: mct_step_controller

Overview:
- Operator and monitor sequencer for the timer's stop/start inputs.
- Accepts RUN / HALT / STEP-N commands over a valid/ready handshake.
- Drives MSTP and MSTRTP so the timer halts cleanly at a memory-cycle-time (MCT) boundary, marked by a T12 rising edge, and runs exactly N MCTs per step.
- Sits between the monitor/DSKY-test interface and the timer's MSTP/MSTRTP pins, and observes the timer's T12 and GOJAM outputs.

Parameters:
- MSTRT_WIDTH, 2, number of SIM_CLK cycles MSTRTP is held high per step (minimum 1).
- TIMEOUT_CYCLES, 1023, cycles allowed in HALTING or STEPWAIT without a T12 rising edge before a forced timeout.

Ports:
- SIM_CLK  input  1  single clock; all logic rising-edge.
- SIM_RST  input  1  reset, asynchronous, active-low.
- CMD_VALID  input  1  command offered.
- CMD_READY  output  1  command accepted when CMD_VALID & CMD_READY on a clock edge.
- CMD_OP  input  2  00 RUN, 01 HALT, 10 STEP, 11 NOP.
- CMD_COUNT  input  8  MCTs to step; 0 means 256.
- T12  input  1  timer T12 pulse.
- GOJAM  input  1  timer restart.
- MSTP  output  1  monitor stop request to timer.
- MSTRTP  output  1  monitor start pulse to timer.
- HALTED  output  1  controller in HALTED state.
- STEPS_LEFT  output  9  MCTs remaining in the current step sequence.
- TIMEOUT  output  1  sticky; no T12 seen within TIMEOUT_CYCLES.
- MCTCNT  output  16  completed-MCT counter (optional feature).

Behaviour:
- T12 edge is defined as T12 & ~t12_q, where t12_q is T12 registered. It is registered in every state.
- Reset values:
  - State is RUN.
  - MSTP=0, MSTRTP=0, HALTED=0, STEPS_LEFT=0, TIMEOUT=0, CMD_READY=1, MCTCNT=0.
  - The timeout counter and the pending-step register are 0.
- All outputs are registered. An accepted command takes effect on the outputs 1 cycle after acceptance.
- CMD_READY=1 only in RUN and HALTED; it is 0 in HALTING, STRT and STEPWAIT.
- RUN (MSTP=0):
  - HALT → HALTING.
  - STEP → HALTING with the pending count latched from CMD_COUNT.
  - RUN clears TIMEOUT and stays in RUN.
  - NOP has no effect.
- HALTING (MSTP=1):
  - The timeout counter increments each cycle.
  - On a T12 edge: go to STRT if the pending count is nonzero (load STEPS_LEFT from it, then clear it); otherwise go to HALTED.
  - When the counter reaches TIMEOUT_CYCLES: set TIMEOUT, clear the pending count, go to HALTED.
- HALTED (MSTP=1, HALTED=1):
  - STEP → STRT with STEPS_LEFT=CMD_COUNT (0 loads 256).
  - RUN → RUN and clears TIMEOUT.
  - HALT and NOP are accepted and have no effect.
- STRT (MSTP=1):
  - MSTRTP=1 for exactly MSTRT_WIDTH cycles, then go to STEPWAIT.
  - The timeout counter is cleared on entry.
- STEPWAIT (MSTP=1, MSTRTP=0):
  - On a T12 edge: decrement STEPS_LEFT; if the result is 0 go to HALTED, otherwise go to STRT.
  - On timeout: set TIMEOUT, clear STEPS_LEFT, go to HALTED.
- GOJAM high while in STRT or STEPWAIT:
  - Clear STEPS_LEFT, force MSTRTP=0, go to HALTED.
  - A T12 edge in the same cycle is ignored for the decrement; GOJAM wins.
- GOJAM in RUN, HALTING or HALTED has no state effect.
- A T12 edge in the same cycle a command is accepted in RUN is ignored for the new HALTING state. HALTING waits for the next edge.
- Async reset mid-sequence returns everything to reset values immediately. MSTP drops, so the timer free-runs.
- The timeout counter is cleared on every state entry and has width ceil(log2(TIMEOUT_CYCLES+1)).

Optional Feature:
- Macro: MCT_COUNT_EN.
- Defined: MCTCNT increments on every T12 edge in any state and wraps 0xFFFF→0x0000. It is cleared only by reset.
- Undefined: the counter logic is absent and MCTCNT is constant 0.

Test Plan:
- Reset, then T12 pulses every 24 cycles → MSTP=0, HALTED=0, CMD_READY=1 throughout; MCTCNT counts 1,2,3… when MCT_COUNT_EN is defined, stays 0 when undefined.
- HALT in RUN → MSTP=1 next cycle, CMD_READY=0; HALTED=1 one cycle after the next T12 edge.
- From HALTED, STEP with CMD_COUNT=3 → three MSTRTP pulses, each 2 cycles wide, each followed by a T12 edge; STEPS_LEFT reads 3,2,1,0; HALTED=1 after the third edge.
- STEP with CMD_COUNT=5 issued in RUN → HALTING, then 5 MSTRTP pulses after the first T12 edge, then HALTED.
- HALT with T12 held low → TIMEOUT=1 and HALTED=1 after 1023 cycles; a subsequent RUN clears TIMEOUT and drops MSTP.
- GOJAM asserted during STEPWAIT with STEPS_LEFT=4 → STEPS_LEFT=0, HALTED=1, no further MSTRTP pulses. Separately, SIM_RST low mid-STRT → MSTRTP and MSTP go to 0 asynchronously.

Source files
------------

// File: rtl/mct_step_controller_if.sv
// Command channel into the MCT step controller: RUN / HALT / STEP-N offered over valid/ready.
interface mct_step_controller_if;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [1:0] CMD_OP;
  logic [7:0] CMD_COUNT;

  modport master (output CMD_VALID, output CMD_OP, output CMD_COUNT, input CMD_READY);
  modport slave  (input CMD_VALID, input CMD_OP, input CMD_COUNT, output CMD_READY);
endinterface

// File: rtl/mct_step_controller.sv
// Monitor stop/start sequencer: halts the timer on an MCT boundary (T12 edge) and runs N MCTs per step.
// Optional completed-MCT counter on MCTCNT is enabled by defining MCT_COUNT_EN.
module mct_step_controller #(
  parameter int MSTRT_WIDTH    = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                   SIM_CLK,
  input  logic                   SIM_RST,
  mct_step_controller_if.slave   cmd,
  input  logic                   T12,
  input  logic                   GOJAM,
  output logic                   MSTP,
  output logic                   MSTRTP,
  output logic                   HALTED,
  output logic [8:0]             STEPS_LEFT,
  output logic                   TIMEOUT,
  output logic [15:0]            MCTCNT
);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_HALTING,
    ST_HALTED,
    ST_STRT,
    ST_STEPWAIT
  } state_t;

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_HALT = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;

  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int STRT_W = (MSTRT_WIDTH > 1) ? $clog2(MSTRT_WIDTH) : 1;
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [STRT_W-1:0] STRT_LAST = STRT_W'(MSTRT_WIDTH - 1);

  state_t            state;
  logic              t12_q;
  logic              t12_edge;
  logic              accept;
  logic [8:0]        cmd_steps;
  logic [8:0]        pending;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [TMO_W-1:0]  tmo_next;
  logic [STRT_W-1:0] strt_cnt;

  assign t12_edge  = T12 & ~t12_q;
  assign accept    = cmd.CMD_VALID & cmd.CMD_READY;
  assign cmd_steps = (cmd.CMD_COUNT == 8'd0) ? 9'd256 : {1'b0, cmd.CMD_COUNT};
  assign tmo_next  = tmo_cnt + TMO_W'(1);

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) t12_q <= 1'b0;
    else          t12_q <= T12;
  end

  // NOTE: every register here is assigned with <= so all transitions see the pre-edge values.
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state         <= ST_RUN;
      MSTP          <= 1'b0;
      MSTRTP        <= 1'b0;
      HALTED        <= 1'b0;
      STEPS_LEFT    <= '0;
      TIMEOUT       <= 1'b0;
      cmd.CMD_READY <= 1'b1;
      pending       <= '0;
      tmo_cnt       <= '0;
      strt_cnt      <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (accept) begin
            case (cmd.CMD_OP)
              OP_RUN: TIMEOUT <= 1'b0;
              OP_HALT, OP_STEP: begin
                state         <= ST_HALTING;
                MSTP          <= 1'b1;
                cmd.CMD_READY <= 1'b0;
                tmo_cnt       <= '0;
                if (cmd.CMD_OP == OP_STEP) pending <= cmd_steps;
              end
              default: ;
            endcase
          end
        end

        // An edge coinciding with acceptance was consumed in RUN; only later edges count here.
        ST_HALTING: begin
          if (t12_edge) begin
            tmo_cnt <= '0;
            if (pending != 9'd0) begin
              state      <= ST_STRT;
              STEPS_LEFT <= pending;
              pending    <= '0;
              MSTRTP     <= 1'b1;
              strt_cnt   <= '0;
            end else begin
              state         <= ST_HALTED;
              HALTED        <= 1'b1;
              cmd.CMD_READY <= 1'b1;
            end
          end else if (tmo_next == TMO_LAST) begin
            state         <= ST_HALTED;
            HALTED        <= 1'b1;
            cmd.CMD_READY <= 1'b1;
            TIMEOUT       <= 1'b1;
            pending       <= '0;
            tmo_cnt       <= '0;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end

        ST_HALTED: begin
          if (accept) begin
            if (cmd.CMD_OP == OP_STEP) begin
              state         <= ST_STRT;
              STEPS_LEFT    <= cmd_steps;
              MSTRTP        <= 1'b1;
              HALTED        <= 1'b0;
              cmd.CMD_READY <= 1'b0;
              strt_cnt      <= '0;
              tmo_cnt       <= '0;
            end else if (cmd.CMD_OP == OP_RUN) begin
              state   <= ST_RUN;
              MSTP    <= 1'b0;
              HALTED  <= 1'b0;
              TIMEOUT <= 1'b0;
              tmo_cnt <= '0;
            end
          end
        end

        ST_STRT: begin
          if (GOJAM) begin
            state         <= ST_HALTED;
            HALTED        <= 1'b1;
            cmd.CMD_READY <= 1'b1;
            MSTRTP        <= 1'b0;
            STEPS_LEFT    <= '0;
            tmo_cnt       <= '0;
          end else if (strt_cnt == STRT_LAST) begin
            state   <= ST_STEPWAIT;
            MSTRTP  <= 1'b0;
            tmo_cnt <= '0;
          end else begin
            strt_cnt <= strt_cnt + STRT_W'(1);
          end
        end

        // GOJAM outranks a simultaneous T12 edge: the step sequence is abandoned, not advanced.
        ST_STEPWAIT: begin
          tmo_cnt <= '0;
          if (GOJAM) begin
            state         <= ST_HALTED;
            HALTED        <= 1'b1;
            cmd.CMD_READY <= 1'b1;
            MSTRTP        <= 1'b0;
            STEPS_LEFT    <= '0;
          end else if (t12_edge) begin
            STEPS_LEFT <= STEPS_LEFT - 9'd1;
            if (STEPS_LEFT == 9'd1) begin
              state         <= ST_HALTED;
              HALTED        <= 1'b1;
              cmd.CMD_READY <= 1'b1;
            end else begin
              state    <= ST_STRT;
              MSTRTP   <= 1'b1;
              strt_cnt <= '0;
            end
          end else if (tmo_next == TMO_LAST) begin
            state         <= ST_HALTED;
            HALTED        <= 1'b1;
            cmd.CMD_READY <= 1'b1;
            TIMEOUT       <= 1'b1;
            STEPS_LEFT    <= '0;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end

        default: begin
          state         <= ST_RUN;
          MSTP          <= 1'b0;
          MSTRTP        <= 1'b0;
          HALTED        <= 1'b0;
          cmd.CMD_READY <= 1'b1;
        end
      endcase
    end
  end

`ifdef MCT_COUNT_EN
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST)      MCTCNT <= '0;
    else if (t12_edge) MCTCNT <= MCTCNT + 16'd1;
  end
`else
  assign MCTCNT = '0;
`endif

endmodule

// File: tb/tb_mct_step_controller.sv
// Directed bench for mct_step_controller; MSTRTP pulses are checked against a queue of expected pulses.
module tb_mct_step_controller;

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_HALT = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  typedef struct {
    int steps;
    int width;
  } pulse_t;

  logic        clk;
  logic        rst_n;
  logic        t12;
  logic        gojam;
  logic        mstp;
  logic        mstrtp;
  logic        halted;
  logic [8:0]  steps_left;
  logic        timeout;
  logic [15:0] mctcnt;

  mct_step_controller_if cmd_if ();

  mct_step_controller dut (
    .SIM_CLK    (clk),
    .SIM_RST    (rst_n),
    .cmd        (cmd_if),
    .T12        (t12),
    .GOJAM      (gojam),
    .MSTP       (mstp),
    .MSTRTP     (mstrtp),
    .HALTED     (halted),
    .STEPS_LEFT (steps_left),
    .TIMEOUT    (timeout),
    .MCTCNT     (mctcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     tests   = 0;
  int     fails   = 0;
  int     exp_mct = 0;
  pulse_t exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic count_t12();
`ifdef MCT_COUNT_EN
    exp_mct++;
`endif
  endtask

  task automatic t12_pulse();
    t12 = 1'b1;
    tick();
    t12 = 1'b0;
    count_t12();
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] count, input logic with_t12);
    check("cmd_ready_before_send", cmd_if.CMD_READY, 1);
    cmd_if.CMD_VALID = 1'b1;
    cmd_if.CMD_OP    = op;
    cmd_if.CMD_COUNT = count;
    t12              = with_t12;
    tick();
    cmd_if.CMD_VALID = 1'b0;
    cmd_if.CMD_OP    = OP_NOP;
    t12              = 1'b0;
    if (with_t12) count_t12();
  endtask

  task automatic wait_mstrtp_low();
    int n = 0;
    while (mstrtp && n < 16) begin
      tick();
      n++;
    end
    check("mstrtp_fall_within_bound", mstrtp, 0);
  endtask

  // Apply n T12 edges after successive start pulses, expecting STEPS_LEFT to count down from 'from'.
  task automatic step_edges(input int n, input int from, input bool_last);
    for (int i = 0; i < n; i++) begin
      wait_mstrtp_low();
      check("halted_during_step", halted, 0);
      t12_pulse();
      check("steps_left_after_edge", steps_left, from - 1 - i);
      if (bool_last && i == n - 1) check("mstrtp_after_last_edge", mstrtp, 0);
      else                         check("mstrtp_restart", mstrtp, 1);
    end
  endtask

  task automatic push_pulses(input int first, input int n, input int width);
    for (int i = 0; i < n; i++) exp_q.push_back('{steps: first - i, width: width});
  endtask

  // Scoreboard side: measure each MSTRTP pulse and compare it with the next expected one.
  bit in_pulse  = 1'b0;
  int pulse_w   = 0;
  int pulse_sl  = 0;
  always @(negedge clk) begin
    if (mstrtp) begin
      if (!in_pulse) begin
        in_pulse = 1'b1;
        pulse_w  = 0;
        pulse_sl = int'(steps_left);
      end
      pulse_w++;
    end else if (in_pulse) begin
      pulse_t e;
      in_pulse = 1'b0;
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_mstrtp_pulse: got steps_left %0d width %0d expected no pulse", pulse_sl, pulse_w);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pulse_steps_left", pulse_sl, e.steps);
        check("pulse_width", pulse_w, e.width);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    rst_n            = 1'b0;
    t12              = 1'b0;
    gojam            = 1'b0;
    cmd_if.CMD_VALID = 1'b0;
    cmd_if.CMD_OP    = OP_NOP;
    cmd_if.CMD_COUNT = 8'd0;
    tick();

    // Reset values
    check("rst_mstp", mstp, 0);
    check("rst_mstrtp", mstrtp, 0);
    check("rst_halted", halted, 0);
    check("rst_steps_left", steps_left, 0);
    check("rst_timeout", timeout, 0);
    check("rst_cmd_ready", cmd_if.CMD_READY, 1);
    check("rst_mctcnt", mctcnt, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Free run with T12 every 24 cycles; GOJAM in RUN has no effect
    for (int p = 0; p < 3; p++) begin
      repeat (23) tick();
      t12_pulse();
      check("run_mstp", mstp, 0);
      check("run_halted", halted, 0);
      check("run_cmd_ready", cmd_if.CMD_READY, 1);
      check("run_mctcnt", mctcnt, exp_mct);
    end
    gojam = 1'b1;
    repeat (2) tick();
    gojam = 1'b0;
    check("gojam_run_mstp", mstp, 0);
    check("gojam_run_ready", cmd_if.CMD_READY, 1);

    // HALT in RUN, then halt on the next T12 edge
    send(OP_HALT, 8'd0, 1'b0);
    check("halting_mstp", mstp, 1);
    check("halting_ready", cmd_if.CMD_READY, 0);
    check("halting_halted", halted, 0);
    repeat (5) tick();
    check("halting_wait_halted", halted, 0);
    t12_pulse();
    check("halted_after_edge", halted, 1);
    check("halted_ready", cmd_if.CMD_READY, 1);
    check("halted_mstp", mstp, 1);

    // STEP 3 from HALTED
    push_pulses(3, 3, 2);
    send(OP_STEP, 8'd3, 1'b0);
    check("step3_steps_left", steps_left, 3);
    check("step3_ready", cmd_if.CMD_READY, 0);
    step_edges(3, 3, 1'b1);
    check("step3_halted", halted, 1);
    check("step3_mctcnt", mctcnt, exp_mct);

    // Back to RUN, then STEP 5 from RUN with a T12 edge in the accept cycle
    send(OP_RUN, 8'd0, 1'b0);
    check("run_again_mstp", mstp, 0);
    check("run_again_halted", halted, 0);
    push_pulses(5, 5, 2);
    send(OP_STEP, 8'd5, 1'b1);
    check("step5_mstp", mstp, 1);
    repeat (3) tick();
    check("step5_ignore_accept_edge_mstrtp", mstrtp, 0);
    check("step5_ignore_accept_edge_halted", halted, 0);
    t12_pulse();
    check("step5_strt_steps_left", steps_left, 5);
    check("step5_strt_mstrtp", mstrtp, 1);
    step_edges(5, 5, 1'b1);
    check("step5_halted", halted, 1);

    // HALT timeout with T12 held low
    send(OP_RUN, 8'd0, 1'b0);
    send(OP_HALT, 8'd0, 1'b0);
    c = 0;
    while (!halted && c < 1100) begin
      tick();
      c++;
      if (c == 1000) check("timeout_not_early", timeout, 0);
    end
    check("timeout_cycles", c, 1023);
    check("timeout_flag", timeout, 1);
    check("timeout_halted", halted, 1);
    send(OP_NOP, 8'd0, 1'b0);
    check("timeout_sticky_nop", timeout, 1);
    send(OP_RUN, 8'd0, 1'b0);
    check("timeout_cleared", timeout, 0);
    check("timeout_run_mstp", mstp, 0);

    // GOJAM during STEPWAIT with STEPS_LEFT=4 (simultaneous T12 edge ignored)
    send(OP_HALT, 8'd0, 1'b0);
    tick();
    t12_pulse();
    check("gj_halted_pre", halted, 1);
    push_pulses(6, 3, 2);
    send(OP_STEP, 8'd6, 1'b0);
    step_edges(2, 6, 1'b0);
    wait_mstrtp_low();
    check("gj_steps_left_pre", steps_left, 4);
    gojam = 1'b1;
    t12   = 1'b1;
    tick();
    gojam = 1'b0;
    t12   = 1'b0;
    count_t12();
    check("gj_steps_left", steps_left, 0);
    check("gj_halted", halted, 1);
    check("gj_mstrtp", mstrtp, 0);
    repeat (30) tick();
    check("gj_no_more_pulses", mstrtp, 0);
    check("gj_queue_drained", exp_q.size(), 0);
    check("gj_mctcnt", mctcnt, exp_mct);

    // Async reset in the middle of STRT
    push_pulses(2, 1, 1);
    send(OP_STEP, 8'd2, 1'b0);
    check("rst_mid_strt_mstrtp_pre", mstrtp, 1);
    #2;
    rst_n = 1'b0;
    exp_mct = 0;
    #1;
    check("async_rst_mstrtp", mstrtp, 0);
    check("async_rst_mstp", mstp, 0);
    check("async_rst_steps_left", steps_left, 0);
    check("async_rst_mctcnt", mctcnt, 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("post_rst_ready", cmd_if.CMD_READY, 1);
    check("post_rst_halted", halted, 0);
    check("post_rst_queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
